chess_sound: RTL and testbench

- Audio stage downstream of the Play game-logic block in the chess top level.
- Consumes Play's sound_code/play_sound event and drives the board's mono audio PWM pin.
- Each event code selects a short melody of 1–4 square-wave notes, separated by silent gaps.
- Replaces the stubbed Sound instance; runs in the same clock domain as Play and Keyboard.

---
 rtl/sound_pkg.sv | 48 ++++
 rtl/tone_gen.sv | 28 ++
 rtl/chess_sound.sv | 124 ++++++++++++
 tb/tb_chess_sound.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sound_pkg.sv
// Shared types, note frequencies and melody lookup for the chess audio stage.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package sound_pkg;

    typedef enum logic [1:0] {IDLE, PLAY, GAP} state_t;

    localparam int F_A3 = 220;
    localparam int F_C5 = 523;
    localparam int F_E5 = 659;
    localparam int F_G5 = 784;
    localparam int F_A5 = 880;
    localparam int F_C6 = 1047;

    function automatic int half_cycles(input int clk_hz, input int f);
        return clk_hz / (2 * f);
    endfunction

    function automatic int melody_len(input logic [2:0] code);
        int n;
        case (code)
            3'd0:       n = 1;
            3'd5:       n = 3;
            3'd6, 3'd7: n = 4;
            default:    n = 2;
        endcase
        return n;
    endfunction

    function automatic int melody_freq(input logic [2:0] code, input logic [1:0] idx);
        int f;
        f = F_C6;
        case (code)
            3'd0: f = F_C6;
            3'd1: f = (idx == 2'd0) ? F_E5 : F_G5;
            3'd2: f = (idx == 2'd0) ? F_G5 : F_C6;
            3'd3: f = F_A3;
            3'd4: f = F_A5;
            3'd5: f = (idx == 2'd0) ? F_C5 : (idx == 2'd1) ? F_E5 : F_G5;
            3'd6: f = (idx == 2'd0) ? F_C5 : (idx == 2'd1) ? F_E5 :
                      (idx == 2'd2) ? F_G5 : F_C6;
            default: f = (idx == 2'd0) ? F_C6 : (idx == 2'd1) ? F_G5 :
                         (idx == 2'd2) ? F_E5 : F_C5;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: sq toggles every `half` cycles, held at 0 while clear.
// Latency: first rising edge `half` cycles after clear drops.
// Backpressure: none.
module tone_gen #(
    parameter int HW = 18
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clear,
    input  logic [HW-1:0] half,
    output logic          sq
);

    logic [HW-1:0] half_cnt;

    always_ff @(posedge clk) begin
        if (!rstn || clear) begin
            half_cnt <= '0;
            sq       <= 1'b0;
        end else if (half_cnt == half - HW'(1)) begin
            half_cnt <= '0;
            sq       <= ~sq;
        end else begin
            half_cnt <= half_cnt + HW'(1);
        end
    end

endmodule

// File: rtl/chess_sound.sv
// Melody sequencer: plays 1-4 square-wave notes with silent gaps per sound_code.
// Latency: PLAY entered two edges after play_sound is first sampled high.
// Backpressure: none; a new trigger aborts and restarts the current melody.
module chess_sound
    import sound_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int NOTE_MS = 120,
    parameter int GAP_MS  = 10
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [2:0] sound_code,
    input  logic       play_sound,
    input  logic       enable,
    output logic       pwm,
    output logic       sd,
    output logic       busy
);

    localparam int NOTE_CYC = CLK_HZ / 1000 * NOTE_MS;
    localparam int GAP_CYC  = CLK_HZ / 1000 * GAP_MS;
    localparam int DW       = (NOTE_CYC > 1) ? $clog2(NOTE_CYC) : 1;
    localparam int GW       = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam int HALF_MAX = half_cycles(CLK_HZ, F_A3);
    localparam int HW       = $clog2(HALF_MAX + 1);

    state_t        state, state_nxt;
    logic          prev_ps, arm, trig;
    logic [2:0]    code_s, code_q;
    logic [1:0]    note_idx, idx_nxt;
    logic [DW-1:0] dur_cnt;
    logic [GW-1:0] gap_cnt;
    logic          dur_end, gap_end, last_note, tone_clr, sq;

    // Half-period per (code, note), folded to constants at elaboration.
    logic [HW-1:0] half_tab [32];
    for (genvar g = 0; g < 32; g++) begin : g_half
        assign half_tab[g] = HW'(half_cycles(CLK_HZ, melody_freq(3'(g / 4), 2'(g % 4))));
    end

    // arm blocks a false trigger when play_sound is already high as reset lifts.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            prev_ps <= 1'b0;
            arm     <= ~play_sound;
            trig    <= 1'b0;
            code_s  <= '0;
        end else begin
            prev_ps <= play_sound;
            arm     <= arm | ~play_sound;
            trig    <= play_sound & ~prev_ps & arm;
            if (play_sound && !prev_ps)
                code_s <= sound_code;
        end
    end

    assign dur_end   = (dur_cnt == DW'(NOTE_CYC - 1));
    assign gap_end   = (gap_cnt == GW'(GAP_CYC - 1));
    assign last_note = (note_idx == 2'(melody_len(code_q) - 1));

    always_comb begin
        state_nxt = state;
        idx_nxt   = note_idx;
        if (trig) begin
            state_nxt = PLAY;
            idx_nxt   = 2'd0;
        end else begin
            unique case (state)
                IDLE: state_nxt = IDLE;
                PLAY: if (dur_end) state_nxt = GAP;
                GAP: begin
                    if (gap_end) begin
                        if (last_note) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = PLAY;
                            idx_nxt   = note_idx + 2'd1;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= IDLE;
            note_idx <= 2'd0;
            code_q   <= '0;
            dur_cnt  <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            note_idx <= idx_nxt;
            if (trig)
                code_q <= code_s;
            if (trig || state != PLAY || state_nxt != PLAY)
                dur_cnt <= '0;
            else
                dur_cnt <= dur_cnt + DW'(1);
            if (trig || state != GAP || state_nxt != GAP)
                gap_cnt <= '0;
            else
                gap_cnt <= gap_cnt + GW'(1);
        end
    end

    assign tone_clr = trig | (state != PLAY) | (state_nxt != PLAY);

    tone_gen #(.HW(HW)) u_tone (
        .clk   (clk),
        .rstn  (rstn),
        .clear (tone_clr),
        .half  (half_tab[{code_q, note_idx}]),
        .sq    (sq)
    );

    assign pwm  = sq & enable;
    assign sd   = (state == PLAY) & enable;
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_chess_sound.sv
// Randomized scoreboard bench for chess_sound: expected output change events
// are queued at stimulus time and matched by a negedge monitor.
module tb_chess_sound;

    localparam int CLK_HZ  = 1_000_000;
    localparam int NOTE_MS = 2;
    localparam int GAP_MS  = 1;
    localparam int NOTE    = CLK_HZ / 1000 * NOTE_MS;
    localparam int GAPC    = CLK_HZ / 1000 * GAP_MS;
    localparam int SLOT    = NOTE + GAPC;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic [2:0] sound_code = 3'd0;
    logic       play_sound = 1'b0;
    logic       enable = 1'b1;
    logic       pwm, sd, busy;

    chess_sound #(.CLK_HZ(CLK_HZ), .NOTE_MS(NOTE_MS), .GAP_MS(GAP_MS)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .sound_code (sound_code),
        .play_sound (play_sound),
        .enable     (enable),
        .pwm        (pwm),
        .sd         (sd),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         c;
        logic [2:0] v;
    } ev_t;

    ev_t q[$];
    int  errors = 0;
    int  checks = 0;

    int freq_tab [8][4] = '{'{1047, 0, 0, 0}, '{659, 784, 0, 0}, '{784, 1047, 0, 0},
                            '{220, 220, 0, 0}, '{880, 880, 0, 0}, '{523, 659, 784, 0},
                            '{523, 659, 784, 1047}, '{1047, 784, 659, 523}};
    int len_tab [8] = '{1, 2, 2, 2, 2, 3, 4, 4};

    int m_code  = 0;
    int m_start = 0;
    bit m_en    = 1'b1;
    bit m_act   = 1'b0;

    // Expected {pwm, sd, busy} at absolute cycle c for a melody entering PLAY at start.
    function automatic logic [2:0] model(input int code, input int start, input bit en, input int c);
        int t, n, tn, h;
        logic [2:0] v;
        v = 3'b000;
        if (c >= start) begin
            t  = c - start;
            n  = t / SLOT;
            tn = t % SLOT;
            if (n < len_tab[code]) begin
                if (tn < NOTE) begin
                    h = CLK_HZ / (2 * freq_tab[code][n]);
                    v = {(((tn / h) % 2) == 1) & en, en, 1'b1};
                end else begin
                    v = 3'b001;
                end
            end
        end
        return v;
    endfunction

    function automatic logic [2:0] cur_model(input int c);
        return m_act ? model(m_code, m_start, m_en, c) : 3'b000;
    endfunction

    task automatic truncate(input int c);
        while (q.size() > 0 && q[q.size()-1].c >= c)
            q.delete(q.size() - 1);
    endtask

    task automatic start_melody(input int code, input bit en, input int e);
        logic [2:0] prev, v;
        prev = cur_model(e - 1);
        truncate(e);
        m_code = code; m_start = e; m_en = en; m_act = 1'b1;
        for (int c = e; c <= e + len_tab[code] * SLOT; c++) begin
            v = model(code, e, en, c);
            if (v != prev) q.push_back('{c, v});
            prev = v;
        end
    endtask

    task automatic pulse(input logic [2:0] code, input int hold);
        @(posedge clk); #1;
        sound_code = code;
        play_sound = 1'b1;
        start_melody(int'(code), enable, cyc + 2);
        repeat (hold) @(posedge clk);
        #1;
        play_sound = 1'b0;
        sound_code = 3'($urandom);
    endtask

    task automatic mid_reset();
        logic [2:0] prevv;
        int c;
        @(posedge clk); #1;
        rstn  = 1'b0;
        c     = cyc;
        prevv = cur_model(c);
        truncate(c + 1);
        if (prevv != 3'b000) q.push_back('{c + 1, 3'b000});
        m_act = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
    endtask

    task automatic wait_idle(input string name, input int max_cyc);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cyc && !done; i++) begin
            @(negedge clk); #1;
            if (!busy && q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: busy=%b queued=%0d, required idle within %0d cycles",
                     name, busy, q.size(), max_cyc);
            q.delete();
        end
    endtask

    task automatic chk(input string name, input logic [2:0] got, input logic [2:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%b required=%b", name, got, exp);
        end
    endtask

    bit         mon_on = 1'b0;
    logic [2:0] last_v = 3'b000;
    logic [2:0] mon_v;
    ev_t        mon_e;

    always @(negedge clk) begin
        if (mon_on) begin
            mon_v = {pwm, sd, busy};
            if (mon_v !== last_v) begin
                checks++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_change cyc=%0d {pwm,sd,busy}=%b, required no change from %b",
                             cyc, mon_v, last_v);
                end else begin
                    mon_e = q.pop_front();
                    if (mon_e.c != cyc || mon_e.v !== mon_v) begin
                        errors++;
                        $display("FAIL event cyc=%0d {pwm,sd,busy}=%b, required cyc=%0d value=%b",
                                 cyc, mon_v, mon_e.c, mon_e.v);
                    end
                end
                last_v = mon_v;
            end else if (q.size() > 0 && q[0].c <= cyc) begin
                checks++;
                errors++;
                mon_e = q.pop_front();
                $display("FAIL missed_event cyc=%0d {pwm,sd,busy}=%b, required %b at cyc=%0d",
                         cyc, mon_v, mon_e.v, mon_e.c);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout at cyc=%0d", cyc);
        $fatal(1, "global timeout");
    end

    initial begin
        int code, hold;
        rstn       = 1'b0;
        play_sound = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pwm",  {2'b00, pwm},  3'b000);
        chk("reset_sd",   {2'b00, sd},   3'b000);
        chk("reset_busy", {2'b00, busy}, 3'b000);
        @(posedge clk); #1;
        rstn   = 1'b1;
        last_v = 3'b000;
        mon_on = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        chk("held_through_reset_busy", {2'b00, busy}, 3'b000);
        play_sound = 1'b0;
        repeat (5) @(posedge clk);

        pulse(3'd0, 1);    wait_idle("code0", 5000);
        pulse(3'd6, 1);    wait_idle("code6", 15000);
        pulse(3'd3, 5000); wait_idle("code3_held", 5000);

        pulse(3'd7, 1);
        repeat (498) @(posedge clk);
        pulse(3'd1, 1);    wait_idle("retrigger", 8000);

        enable = 1'b0;
        pulse(3'd2, 1);    wait_idle("mute", 8000);
        enable = 1'b1;

        pulse(3'd5, 1);
        repeat (2500) @(posedge clk);
        mid_reset();
        pulse(3'd4, 1);    wait_idle("after_reset", 8000);

        for (int i = 0; i < 5; i++) begin
            code = $urandom_range(0, 7);
            hold = $urandom_range(1, 4);
            pulse(3'(code), hold);
            repeat ($urandom_range(100, 4000)) @(posedge clk);
            if ($urandom_range(0, 2) == 0) begin
                wait_idle("random", 15000);
                enable = 1'($urandom_range(0, 1));
            end
        end
        wait_idle("drain", 15000);
        enable = 1'b1;

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL queue_empty queued=%0d required=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
